// File: rtl/fp_pkg.sv
// fp_pkg: shared floating-point register-file widths, types and the hardwired-zero register
package fp_pkg;
  localparam int FP_REG_ADDR_W = 5;
  localparam int FLEN = 32;
  localparam int NUM_FP_REGS = 32;
  typedef logic [FP_REG_ADDR_W-1:0] fp_reg_addr_t;
  typedef logic [FLEN-1:0] fp_word_t;
  localparam fp_reg_addr_t FP_ZERO_REG = 5'd0;
endpackage

// File: rtl/rr_arbiter.sv
// rr_arbiter: combinational round-robin pick (req, ptr, en -> one-hot gnt, gnt_idx, any_gnt), first valid at or after ptr
module rr_arbiter #(
  parameter int N = 3,
  localparam int IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  input  logic          en,
  output logic [N-1:0]  gnt,
  output logic [IW-1:0] gnt_idx,
  output logic          any_gnt
);
  logic [N-1:0] hi;
  always_comb begin
    hi = '0;
    gnt_idx = '0;
    for (int i = 0; i < N; i++) hi[i] = req[i] && (IW'(i) >= ptr);
    for (int i = N - 1; i >= 0; i--) if (req[i]) gnt_idx = IW'(i);
    for (int i = N - 1; i >= 0; i--) if (hi[i]) gnt_idx = IW'(i);
    any_gnt = en && |req;
    gnt = any_gnt ? (N'(1) << gnt_idx) : '0;
  end
endmodule

// File: rtl/fp_wb_arbiter.sv
// fp_wb_arbiter: round-robin share of the FP register-file write port (req_* handshake in, registered wr_* out, saturating conflict_cnt)
module fp_wb_arbiter
  import fp_pkg::*;
#(
  parameter int N_REQ = 3,
  parameter int CNT_W = 16,
  localparam int IW = $clog2(N_REQ)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [N_REQ-1:0]     req_valid,
  input  logic [N_REQ*5-1:0]   req_addr,
  input  logic [N_REQ*32-1:0]  req_data,
  output logic [N_REQ-1:0]     req_ready,
  input  logic                 wb_hold,
  output logic                 wr_enable,
  output fp_reg_addr_t         wr_addr,
  output fp_word_t             wr_data,
  output logic [IW-1:0]        wr_src,
  output logic [CNT_W-1:0]     conflict_cnt
);
  fp_reg_addr_t addr_a [N_REQ];
  fp_word_t data_a [N_REQ];
  logic [IW-1:0] rr_ptr, gnt_idx;
  logic any_gnt;
  for (genvar g = 0; g < N_REQ; g++) begin : g_unpack
    assign addr_a[g] = req_addr[5*g +: 5];
    assign data_a[g] = req_data[32*g +: 32];
  end
  rr_arbiter #(.N(N_REQ)) u_arb (
    .req(req_valid),
    .ptr(rr_ptr),
    .en(!wb_hold && !rst),
    .gnt(req_ready),
    .gnt_idx(gnt_idx),
    .any_gnt(any_gnt)
  );
  always_ff @(posedge clk) begin
    if (rst) begin
      rr_ptr <= '0;
      wr_enable <= 1'b0;
      wr_addr <= '0;
      wr_data <= '0;
      wr_src <= '0;
      conflict_cnt <= '0;
    end else begin
      wr_enable <= any_gnt && (addr_a[gnt_idx] != FP_ZERO_REG);
      if (any_gnt) begin
        rr_ptr <= (gnt_idx == IW'(N_REQ - 1)) ? '0 : gnt_idx + 1'b1;
        wr_addr <= addr_a[gnt_idx];
        wr_data <= data_a[gnt_idx];
        wr_src <= gnt_idx;
      end
      if ($countones(req_valid) >= 2 && conflict_cnt != '1) conflict_cnt <= conflict_cnt + 1'b1;
    end
  end
endmodule

// File: tb/tb_fp_wb_arbiter.sv
// tb_fp_wb_arbiter: directed plus random checks of fp_wb_arbiter against a round-robin reference model
module tb_fp_wb_arbiter;
  logic clk, rst, wb_hold;
  logic [2:0] req_valid, req_ready, rdy4;
  logic [14:0] req_addr;
  logic [95:0] req_data;
  logic wr_enable, we4;
  logic [4:0] wr_addr, wa4;
  logic [31:0] wr_data, wd4;
  logic [1:0] wr_src, ws4;
  logic [15:0] conflict_cnt;
  logic [3:0] cnt4;
  int total = 0, bad = 0;
  int mptr = 0, last_win = -1;
  logic m_we = 0;
  logic [4:0] m_addr = 0;
  logic [31:0] m_data = 0;
  logic [1:0] m_src = 0;
  logic [15:0] m_cnt = 0;
  logic [3:0] m_cnt4 = 0;
  fp_wb_arbiter dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_addr(req_addr), .req_data(req_data),
    .req_ready(req_ready), .wb_hold(wb_hold), .wr_enable(wr_enable), .wr_addr(wr_addr),
    .wr_data(wr_data), .wr_src(wr_src), .conflict_cnt(conflict_cnt)
  );
  fp_wb_arbiter #(.CNT_W(4)) dut4 (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_addr(req_addr), .req_data(req_data),
    .req_ready(rdy4), .wb_hold(wb_hold), .wr_enable(we4), .wr_addr(wa4),
    .wr_data(wd4), .wr_src(ws4), .conflict_cnt(cnt4)
  );
  initial clk = 0;
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] o, input logic [31:0] e);
    total++;
    assert (o === e) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, o, e);
    end
  endtask
  task automatic cyc(input logic r, input logic [2:0] v, input logic h, input logic [14:0] a, input logic [95:0] d);
    logic [2:0] exp_ready;
    int win;
    rst = r; req_valid = v; wb_hold = h; req_addr = a; req_data = d;
    #1;
    win = -1;
    exp_ready = '0;
    if (!r && !h)
      for (int k = 0; k < 3; k++)
        if (win < 0 && v[(mptr + k) % 3]) win = (mptr + k) % 3;
    if (win >= 0) exp_ready[win] = 1'b1;
    chk("ready", 32'(req_ready), 32'(exp_ready));
    @(posedge clk);
    #1;
    if (r) begin
      mptr = 0; m_we = 0; m_addr = 0; m_data = 0; m_src = 0; m_cnt = 0; m_cnt4 = 0;
    end else begin
      m_we = (win >= 0) && (a[win*5 +: 5] != 5'd0);
      if (win >= 0) begin
        m_addr = a[win*5 +: 5];
        m_data = d[win*32 +: 32];
        m_src = 2'(win);
        mptr = (win + 1) % 3;
      end
      if ($countones(v) >= 2) begin
        if (m_cnt != 16'hFFFF) m_cnt = m_cnt + 1;
        if (m_cnt4 != 4'hF) m_cnt4 = m_cnt4 + 1;
      end
    end
    last_win = win;
    chk("wr_enable", 32'(wr_enable), 32'(m_we));
    chk("wr_addr", 32'(wr_addr), 32'(m_addr));
    chk("wr_data", wr_data, m_data);
    chk("wr_src", 32'(wr_src), 32'(m_src));
    chk("conflict_cnt", 32'(conflict_cnt), 32'(m_cnt));
    chk("conflict_cnt4", 32'(cnt4), 32'(m_cnt4));
  endtask
  initial begin
    logic pv [3];
    logic [4:0] pa [3];
    logic [31:0] pd [3];
    logic [2:0] v;
    logic [14:0] a;
    logic [95:0] d;
    rst = 1; req_valid = 0; wb_hold = 0; req_addr = 0; req_data = 0;
    cyc(1, 3'b000, 0, 15'd0, 96'd0);
    cyc(1, 3'b000, 0, 15'd0, 96'd0);
    cyc(0, 3'b001, 0, {5'd0, 5'd0, 5'd5}, {32'd0, 32'd0, 32'h3F800000});
    chk("single_addr", 32'(wr_addr), 32'd5);
    chk("single_we", 32'(wr_enable), 32'd1);
    cyc(1, 3'b000, 0, 15'd0, 96'd0);
    for (int i = 0; i < 4; i++)
      cyc(0, 3'b111, 0, {5'd3, 5'd2, 5'd1}, {32'hC, 32'hB, 32'hA});
    chk("rr_cnt4", 32'(conflict_cnt), 32'd4);
    chk("rr_src_last", 32'(wr_src), 32'd0);
    cyc(0, 3'b010, 0, {5'd0, 5'd0, 5'd0}, {32'd0, 32'hDEADBEEF, 32'd0});
    chk("f0_suppressed", 32'(wr_enable), 32'd0);
    for (int i = 0; i < 3; i++)
      cyc(0, 3'b100, 1, {5'd9, 5'd0, 5'd0}, {32'h1234, 32'd0, 32'd0});
    cyc(0, 3'b100, 0, {5'd9, 5'd0, 5'd0}, {32'h1234, 32'd0, 32'd0});
    chk("hold_release_src", 32'(wr_src), 32'd2);
    cyc(0, 3'b001, 0, {5'd0, 5'd0, 5'd7}, {32'd0, 32'd0, 32'h77});
    cyc(1, 3'b001, 0, {5'd0, 5'd0, 5'd7}, {32'd0, 32'd0, 32'h77});
    chk("reset_discard", 32'(wr_enable), 32'd0);
    for (int i = 0; i < 20; i++)
      cyc(0, 3'b011, 0, {5'd0, 5'd4, 5'd6}, {32'd0, 32'h44, 32'h66});
    chk("sat4", 32'(cnt4), 32'd15);
    for (int i = 0; i < 3; i++) pv[i] = 0;
    for (int n = 0; n < 300; n++) begin
      for (int i = 0; i < 3; i++)
        if (!pv[i] && $urandom_range(0, 2) == 0) begin
          pv[i] = 1;
          pa[i] = 5'($urandom_range(0, 31));
          pd[i] = $urandom;
        end
      for (int i = 0; i < 3; i++) begin
        v[i] = pv[i];
        a[i*5 +: 5] = pa[i];
        d[i*32 +: 32] = pd[i];
      end
      cyc($urandom_range(0, 30) == 0, v, $urandom_range(0, 4) == 0, a, d);
      if (last_win >= 0) pv[last_win] = 0;
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/fp_wb_arbiter.md
Name: fp_wb_arbiter

Overview:
- Shares the single write port of the 32x32 floating-point register file among N writeback requesters (FP add, FP mul/div, FP load).
- Uses round-robin arbitration with a valid/ready handshake per requester.
- Drives the register-file write port from a registered output stage, giving one-cycle latency.
- Also keeps a saturating conflict counter for performance analysis.

Parameters:
- N_REQ, 3, number of writeback requesters (2..8).
- CNT_W, 16, width of the saturating conflict counter.

Ports:
- clk  input  1  clock
- rst  input  1  reset, synchronous, active-high
- req_valid  input  N_REQ  requester i has a write pending
- req_addr  input  N_REQ*5  destination register of requester i, packed at [5i+4:5i]
- req_data  input  N_REQ*32  write data of requester i, packed at [32i+31:32i]
- req_ready  output  N_REQ  one-hot (or zero) grant to requester i this cycle
- wb_hold  input  1  stall; when high, no grant is issued
- wr_enable  output  1  register-file write enable
- wr_addr  output  5  register-file write address
- wr_data  output  32  register-file write data
- wr_src  output  $clog2(N_REQ)  index of the requester whose write is on the port
- conflict_cnt  output  CNT_W  count of cycles with more than one requester valid

Behaviour:
- Handshake:
  - Transfer happens when req_valid[i] && req_ready[i] in the same cycle.
  - A requester holds valid, addr and data stable until that transfer.
  - req_ready is combinational from req_valid, rr_ptr, wb_hold and rst.
  - At most one req_ready bit is high per cycle.
- Arbitration:
  - Winner is the first valid index found scanning rr_ptr, rr_ptr+1, ... modulo N_REQ.
  - On a transfer, rr_ptr <= (winner+1) mod N_REQ; wrap from N_REQ-1 to 0.
  - With no transfer, rr_ptr holds.
  - Starvation bound: a continuously valid requester is granted within N_REQ cycles of no-hold.
- Output stage (registered, latency 1):
  - On a transfer in cycle t, cycle t+1 shows wr_addr=req_addr[w], wr_data=req_data[w], wr_src=w.
  - wr_enable=1 in cycle t+1 unless req_addr[w]==0. Writes to f0 are accepted (ready given) but suppressed (wr_enable=0), because f0 reads as zero.
  - Cycle after no transfer: wr_enable=0; wr_addr, wr_data and wr_src hold their previous values.
- wb_hold=1: req_ready=0, rr_ptr holds, wr_enable=0 next cycle. Requesters keep their requests.
- Same destination from two requesters in one cycle: only the winner transfers; the other is served in a later cycle. The later grant wins in the register file, so ordering is the requesters' responsibility.
- conflict_cnt: increments when popcount(req_valid)>=2 and rst=0, independent of wb_hold. It saturates at 2^CNT_W-1 and does not wrap.
- Reset (rst=1, sampled at clk):
  - req_ready=0 combinationally.
  - Next cycle: wr_enable=0, wr_addr=0, wr_data=0, wr_src=0, rr_ptr=0, conflict_cnt=0.
  - A write accepted in the cycle before rst asserts is discarded: wr_enable=0 after reset.
- Idle (no valid): req_ready=0, wr_enable=0, conflict_cnt unchanged.

Decomposition:
- Shared package fp_pkg holds:
  - FP_REG_ADDR_W=5, FLEN=32, NUM_FP_REGS=32
  - typedef fp_reg_addr_t = logic [4:0]
  - typedef fp_word_t = logic [31:0]
  - FP_ZERO_REG=5'd0
- Sub-module rr_arbiter (parameter N): inputs req, ptr, en; outputs one-hot gnt, gnt_idx, any_gnt. It is purely combinational and reusable for the integer writeback port.
- The pointer, output registers and counter stay in fp_wb_arbiter.

Test Plan:
- Reset, then single request: req_valid=3'b001, addr=5, data=32'h3F800000 -> req_ready=3'b001 same cycle; next cycle wr_enable=1, wr_addr=5, wr_data=32'h3F800000, wr_src=0; rr_ptr=1.
- All three valid continuously from rr_ptr=0, distinct addrs 1,2,3 -> grants 0,1,2,0 over four cycles; wr_src sequence 0,1,2,0 one cycle later; conflict_cnt increments each cycle (1,2,3,4).
- Write to f0: req 1 valid, addr=0, data=32'hDEADBEEF -> req_ready[1]=1; next cycle wr_enable=0; rr_ptr advances to 2.
- wb_hold=1 for 3 cycles with req 2 valid -> req_ready=0 and wr_enable=0 throughout, rr_ptr unchanged. Hold drops -> grant to 2 in that cycle, write visible next cycle.
- Reset mid-operation: grant to req 0 in cycle t, rst=1 in cycle t+1 -> req_ready=0 during rst; wr_enable=0 and conflict_cnt=0 afterwards; rr_ptr=0.
- Saturation: CNT_W=4, hold 2 requesters valid for 20 cycles -> conflict_cnt reaches 15 and stays 15.
